vector_seq: RTL



---
 rtl/vector_seq_if.sv | 23 ++
 rtl/vector_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/vector_seq_if.sv
// rtl/vector_seq_if.sv - display-list memory and line-generator bus of the vector sequencer
// Master side is the sequencer; slave side is the RAM plus line generator pair.
interface vector_seq_if #(
    parameter int BITS      = 16,
    parameter int ADDR_BITS = 10
);
    logic [ADDR_BITS-1:0] mem_addr;
    logic [2*BITS+1:0]    mem_data;
    logic                 lt_strobe;
    logic [BITS-1:0]      lt_x;
    logic [BITS-1:0]      lt_y;
    logic                 lt_ready;

    modport master (
        output mem_addr, lt_strobe, lt_x, lt_y,
        input  mem_data, lt_ready
    );

    modport slave (
        input  mem_addr, lt_strobe, lt_x, lt_y,
        output mem_data, lt_ready
    );
endinterface

// File: rtl/vector_seq.sv
// rtl/vector_seq.sv - display-list sequencer driving the line generator
// Walks point memory, strobes each destination, and sequences beam blanking, settle and dwell.
module vector_seq #(
    parameter int BITS         = 16,
    parameter int ADDR_BITS    = 10,
    parameter int BLANK_SETTLE = 8,
    parameter int DWELL        = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         run,
    vector_seq_if.master bus,
    output logic         bright,
    output logic         frame_done,
    output logic         busy
);
    localparam int CNT_MAX = (BLANK_SETTLE > DWELL) ? BLANK_SETTLE : DWELL;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(BLANK_SETTLE - 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'(DWELL - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, LATCH, SETTLE, STROBE, WAIT, DWELL_ST, EOF
    } state_t;

    state_t state, next_state;

    logic [ADDR_BITS-1:0] mem_addr_q, addr_d;
    logic                 strobe_q, strobe_d;
    logic [BITS-1:0]      x_q, x_d, y_q, y_d;
    logic                 bright_q, bright_d;
    logic                 fd_q, fd_d;
    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 first_wait_q, first_wait_d;
    logic                 ent_bright_q, ent_bright_d;
    logic [BITS-1:0]      ent_x_q, ent_x_d, ent_y_q, ent_y_d;

    logic            mem_end, mem_bright;
    logic [BITS-1:0] mem_x, mem_y;
    logic            at_last;
    state_t          after_entry;

    assign mem_end    = bus.mem_data[2*BITS+1];
    assign mem_bright = bus.mem_data[2*BITS];
    assign mem_x      = bus.mem_data[2*BITS-1:BITS];
    assign mem_y      = bus.mem_data[BITS-1:0];
    assign at_last    = (mem_addr_q == {ADDR_BITS{1'b1}});

    assign bus.mem_addr  = mem_addr_q;
    assign bus.lt_strobe = strobe_q;
    assign bus.lt_x      = x_q;
    assign bus.lt_y      = y_q;
    assign bright        = bright_q;
    assign frame_done    = fd_q;
    assign busy          = busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            mem_addr_q   <= '0;
            strobe_q     <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            bright_q     <= 1'b0;
            fd_q         <= 1'b0;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
            first_wait_q <= 1'b0;
            ent_bright_q <= 1'b0;
            ent_x_q      <= '0;
            ent_y_q      <= '0;
        end else begin
            state        <= next_state;
            mem_addr_q   <= addr_d;
            strobe_q     <= strobe_d;
            x_q          <= x_d;
            y_q          <= y_d;
            bright_q     <= bright_d;
            fd_q         <= fd_d;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
            first_wait_q <= first_wait_d;
            ent_bright_q <= ent_bright_d;
            ent_x_q      <= ent_x_d;
            ent_y_q      <= ent_y_d;
        end
    end

    // Run is only sampled between entries (here) and in IDLE/EOF.
    always_comb begin
        after_entry = at_last ? EOF : (run ? FETCH : IDLE);
        next_state  = state;
        case (state)
            IDLE:     if (run) next_state = FETCH;
            FETCH:    next_state = LATCH;
            LATCH: begin
                if (mem_end)                             next_state = EOF;
                else if (!mem_bright && BLANK_SETTLE != 0) next_state = SETTLE;
                else                                     next_state = STROBE;
            end
            SETTLE:   if (cnt_q == '0) next_state = STROBE;
            STROBE:   next_state = WAIT;
            // The generator's ready still reflects the old target in the first WAIT cycle.
            WAIT:     if (!first_wait_q && bus.lt_ready)
                          next_state = (DWELL != 0) ? DWELL_ST : after_entry;
            DWELL_ST: if (cnt_q == '0) next_state = after_entry;
            EOF:      next_state = run ? FETCH : IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        addr_d       = mem_addr_q;
        strobe_d     = 1'b0;
        x_d          = x_q;
        y_d          = y_q;
        bright_d     = bright_q;
        fd_d         = (next_state == EOF);
        busy_d       = (next_state != IDLE);
        cnt_d        = cnt_q;
        first_wait_d = (state == STROBE);
        ent_bright_d = ent_bright_q;
        ent_x_d      = ent_x_q;
        ent_y_d      = ent_y_q;

        if (next_state == STROBE) begin
            strobe_d = 1'b1;
            x_d      = (state == LATCH) ? mem_x : ent_x_q;
            y_d      = (state == LATCH) ? mem_y : ent_y_q;
        end

        case (state)
            IDLE: bright_d = 1'b0;
            LATCH: begin
                ent_bright_d = mem_bright;
                ent_x_d      = mem_x;
                ent_y_d      = mem_y;
                if (!mem_end && !mem_bright) begin
                    bright_d = 1'b0;
                    cnt_d    = SETTLE_LOAD;
                end
            end
            SETTLE: if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            STROBE: bright_d = ent_bright_q;
            WAIT:   if (next_state == DWELL_ST) cnt_d = DWELL_LOAD;
            DWELL_ST: if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            EOF: begin
                bright_d = 1'b0;
                addr_d   = '0;
            end
            default: ;
        endcase

        if ((state == WAIT || state == DWELL_ST) &&
            (next_state == FETCH || next_state == IDLE)) begin
            addr_d = mem_addr_q + ADDR_BITS'(1);
            if (next_state == IDLE) bright_d = 1'b0;
        end
    end
endmodule
